// File: rtl/decode_stage.sv
// RV32I (optional RV32M) decode stage with a one-entry registered output bundle.
// Divide/remainder words are held back for DIV_CYCLES extra cycles before they become visible.
module decode_stage #(
  parameter int unsigned EN_M       = 0,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic        i_in_vld,
  output logic        o_in_rdy,
  output logic        o_out_vld,
  input  logic        i_out_rdy,
  input  logic        i_flush,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic [2:0]  o_opImm,
  output logic        o_brUnsigned,
  output logic        o_opaSel,
  output logic        o_opbSel,
  output logic [4:0]  o_aluOp,
  output logic        o_memWrEnable,
  output logic [1:0]  o_wbSel,
  output logic        o_rdWrEnable,
  output logic [4:0]  o_mask,
  output logic        o_isBranch,
  output logic        o_isJump,
  output logic        o_insn_vld,
  output logic        o_mdBusy
);

  typedef enum logic [1:0] {EMPTY, FULL, MD_WAIT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  op_imm;
    logic        br_unsigned;
    logic        opa_sel;
    logic        opb_sel;
    logic [4:0]  alu_op;
    logic        mem_wr_enable;
    logic [1:0]  wb_sel;
    logic        rd_wr_enable;
    logic [4:0]  mask;
    logic        is_branch;
    logic        is_jump;
    logic        insn_vld;
  } bundle_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd2;
  localparam logic [4:0] ALU_SLTU = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_AND  = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;
  localparam logic [4:0] ALU_LUI  = 5'd10;
  localparam logic [4:0] ALU_MUL  = 5'd11;
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  function automatic logic [4:0] mem_mask(input logic [2:0] f3);
    case (f3)
      3'b000:  mem_mask = 5'b00001;
      3'b001:  mem_mask = 5'b00011;
      3'b010:  mem_mask = 5'b01111;
      3'b100:  mem_mask = 5'b10001;
      3'b101:  mem_mask = 5'b10011;
      default: mem_mask = 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  bundle_t    bundle_q, bundle_d;
  bundle_t    dec;
  logic       dec_div;
  logic       accept;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = i_inst[6:0];
  assign f3     = i_inst[14:12];
  assign f7     = i_inst[31:25];

  always_comb begin
    dec          = '0;
    dec.pc       = i_pc;
    dec.inst     = i_inst;
    dec.opb_sel  = 1'b1;
    dec.insn_vld = 1'b1;
    dec_div      = 1'b0;
    case (opcode)
      OP_LUI: begin
        dec.op_imm       = 3'b101;
        dec.alu_op       = ALU_LUI;
        dec.rd_wr_enable = 1'b1;
      end
      OP_AUIPC: begin
        dec.op_imm       = 3'b101;
        dec.opa_sel      = 1'b1;
        dec.rd_wr_enable = 1'b1;
      end
      OP_JAL: begin
        dec.op_imm       = 3'b100;
        dec.opa_sel      = 1'b1;
        dec.wb_sel       = 2'b01;
        dec.is_jump      = 1'b1;
        dec.rd_wr_enable = 1'b1;
      end
      OP_JALR: begin
        dec.wb_sel       = 2'b01;
        dec.is_jump      = 1'b1;
        dec.rd_wr_enable = 1'b1;
        dec.insn_vld     = (f3 == 3'b000);
      end
      OP_BRANCH: begin
        dec.op_imm      = 3'b011;
        dec.opa_sel     = 1'b1;
        dec.is_branch   = 1'b1;
        dec.br_unsigned = f3[2] & f3[1];
        dec.insn_vld    = (f3[2:1] != 2'b01);
      end
      OP_LOAD: begin
        dec.wb_sel       = 2'b10;
        dec.rd_wr_enable = 1'b1;
        dec.mask         = mem_mask(f3);
        dec.insn_vld     = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      OP_STORE: begin
        dec.op_imm        = 3'b010;
        dec.mem_wr_enable = 1'b1;
        dec.mask          = mem_mask(f3);
        dec.insn_vld      = (f3 < 3'b011);
      end
      OP_IMM: begin
        dec.rd_wr_enable = 1'b1;
        if (f3 == 3'b001) begin
          dec.op_imm   = 3'b001;
          dec.alu_op   = ALU_SLL;
          dec.insn_vld = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          dec.op_imm   = 3'b001;
          dec.alu_op   = f7[5] ? ALU_SRA : ALU_SRL;
          dec.insn_vld = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        end else begin
          dec.alu_op = base_alu(f3, 1'b0);
        end
      end
      OP_REG: begin
        dec.opb_sel      = 1'b0;
        dec.rd_wr_enable = 1'b1;
        case (f7)
          7'b0000000: dec.alu_op = base_alu(f3, 1'b0);
          7'b0100000: begin
            dec.alu_op   = base_alu(f3, 1'b1);
            dec.insn_vld = (f3 == 3'b000) || (f3 == 3'b101);
          end
          7'b0000001: begin
            // M ops occupy a contiguous aluOp range indexed by func3.
            if (EN_M != 0) begin
              dec.alu_op = ALU_MUL + {2'b00, f3};
              dec_div    = f3[2];
            end else begin
              dec.insn_vld = 1'b0;
            end
          end
          default: dec.insn_vld = 1'b0;
        endcase
      end
      default: dec.insn_vld = 1'b0;
    endcase
    if (!dec.insn_vld) begin
      dec.rd_wr_enable  = 1'b0;
      dec.mem_wr_enable = 1'b0;
      dec.is_branch     = 1'b0;
      dec.is_jump       = 1'b0;
      dec.alu_op        = ALU_ADD;
      dec_div           = 1'b0;
    end
  end

  assign o_in_rdy = (state_q == EMPTY) || ((state_q == FULL) && i_out_rdy);
  assign accept   = i_in_vld && o_in_rdy && !i_flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bundle_d = bundle_q;
    if (accept) bundle_d = dec;
    if (i_flush) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = dec_div ? MD_WAIT : FULL;
      cnt_d   = dec_div ? DIV_LOAD : 6'd0;
    end else begin
      case (state_q)
        MD_WAIT: begin
          if (cnt_q == 6'd0) state_d = FULL;
          else               cnt_d   = cnt_q - 6'd1;
        end
        FULL:    if (i_out_rdy) state_d = EMPTY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bundle_q <= bundle_d;
    end
  end

  assign o_out_vld     = (state_q == FULL);
  assign o_mdBusy      = (state_q == MD_WAIT);
  assign o_pc          = bundle_q.pc;
  assign o_inst        = bundle_q.inst;
  assign o_opImm       = bundle_q.op_imm;
  assign o_brUnsigned  = bundle_q.br_unsigned;
  assign o_opaSel      = bundle_q.opa_sel;
  assign o_opbSel      = bundle_q.opb_sel;
  assign o_aluOp       = bundle_q.alu_op;
  assign o_memWrEnable = bundle_q.mem_wr_enable;
  assign o_wbSel       = bundle_q.wb_sel;
  assign o_rdWrEnable  = bundle_q.rd_wr_enable;
  assign o_mask        = bundle_q.mask;
  assign o_isBranch    = bundle_q.is_branch;
  assign o_isJump      = bundle_q.is_jump;
  assign o_insn_vld    = bundle_q.insn_vld;

endmodule
